// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: state encoding, sizing
// constants, the default expected table and a settle-terminal helper.
package tt_sweep_pkg;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;
  localparam int CNT_W   = 4;

  // Default expected table: d = (~a & ~b) | ~c, bit i for {a,b,c} = i.
  localparam logic [7:0] TT_DEFAULT = 8'h57;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Counter value on the last HOLD cycle; unused when the settle time is 0.
  function automatic logic [CNT_W-1:0] settle_term(input int settle);
    logic [CNT_W-1:0] term;
    if (settle <= 0) begin
      term = 4'd0;
    end else begin
      term = CNT_W'(settle - 1);
    end
    return term;
  endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// Settle counter for the truth-table sweeper: synchronous clear has
// priority over increment, terminal flag marks the final HOLD cycle.
module sweep_settle_cnt
  import tt_sweep_pkg::*;
#(
  parameter logic [CNT_W-1:0] TERM = 4'd1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks {a,b,c} through 000..111, holds each vector
// SETTLE+1 cycles, compares the unit output against EXPECTED in the last
// cycle and reports a per-vector fail mask, a fail count and a verdict.
// Optional feature macro: TT_SWEEP_EARLY_ABORT_EN (first mismatch ends
// the sweep immediately).
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter logic [7:0] EXPECTED = TT_DEFAULT,
  parameter int         SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_out,
  output logic       vec_a,
  output logic       vec_b,
  output logic       vec_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [3:0] fail_count
);

  localparam logic             SETTLE_ZERO = (SETTLE == 0);
  localparam logic [CNT_W-1:0] TERM        = settle_term(SETTLE);
`ifdef TT_SWEEP_EARLY_ABORT_EN
  localparam logic             EARLY_ABORT = 1'b1;
`else
  localparam logic             EARLY_ABORT = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [7:0]       mask_q, mask_d;
  logic [3:0]       count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             cnt_term_s;
  logic             mismatch_s;
  logic             finish_s;

  sweep_settle_cnt #(
    .TERM (TERM)
  ) u_settle_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .term_o (cnt_term_s)
  );

  // Next-state and registered-output logic for the sweep FSM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    cnt_clr_s  = 1'b0;
    cnt_en_s   = 1'b0;
    mismatch_s = (f_out != EXPECTED[idx_q]);
    finish_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d     = 3'd0;
          mask_d    = 8'h00;
          count_d   = 4'd0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          cnt_clr_s = 1'b1;
          state_d   = SETTLE_ZERO ? ST_SAMPLE : ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt_term_s) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch_s) begin
          mask_d[idx_q] = 1'b1;
          count_d       = count_q + 4'd1;
        end else begin
          count_d = count_q;
        end
        // Last vector, or the first mismatch when early abort is built in.
        finish_s = (idx_q == 3'd7) || (EARLY_ABORT && mismatch_s);
        if (finish_s) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (count_d == 4'd0);
        end else begin
          idx_d     = idx_q + 3'd1;
          cnt_clr_s = 1'b1;
          state_d   = SETTLE_ZERO ? ST_SAMPLE : ST_HOLD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      mask_q  <= 8'h00;
      count_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_a      = idx_q[2];
  assign vec_b      = idx_q[1];
  assign vec_c      = idx_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_mask  = mask_q;
  assign fail_count = count_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: a cycle-count model checks
// the SETTLE=2 instance every cycle, directed sweeps pin literal results,
// and a SETTLE=0 instance is checked vector by vector.
module tb_truth_table_sweeper;

  localparam int ST = 2;
  localparam int S1 = ST + 1;
`ifdef TT_SWEEP_EARLY_ABORT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start, start0;
  logic       f_out, f_out0;
  logic       vec_a, vec_b, vec_c, busy, done, pass;
  logic [7:0] fail_mask;
  logic [3:0] fail_count;
  logic       vec_a0, vec_b0, vec_c0, busy0, done0, pass0;
  logic [7:0] fail_mask0;
  logic [3:0] fail_count0;

  int         mode;
  bit         chk_en;
  int         errors;
  int         checks;
  logic [7:0] exp_tt;

  truth_table_sweeper #(.EXPECTED(8'h57), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_out(f_out),
    .vec_a(vec_a), .vec_b(vec_b), .vec_c(vec_c),
    .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .fail_count(fail_count)
  );

  truth_table_sweeper #(.EXPECTED(8'h57), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .f_out(f_out0),
    .vec_a(vec_a0), .vec_b(vec_b0), .vec_c(vec_c0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(fail_mask0), .fail_count(fail_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Boolean unit beside the sweeper: 0 correct, 1 stuck-1, 2 stuck-0, 3 inverted.
  function automatic logic unit(input int m, input logic [2:0] v);
    logic good;
    good = (~v[2] & ~v[1]) | ~v[0];
    case (m)
      0:       return good;
      1:       return 1'b1;
      2:       return 1'b0;
      default: return ~good;
    endcase
  endfunction

  always_comb f_out  = unit(mode, {vec_a, vec_b, vec_c});
  always_comb f_out0 = unit(0, {vec_a0, vec_b0, vec_c0});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: phase 0 idle, 1 sweeping (m_n = cycles since launch), 2 done cycle.
  int         m_phase, m_n, m_vec, m_count;
  logic [7:0] m_mask;
  bit         m_pass;

  always @(posedge clk or negedge rst_n) begin : model
    int         n_phase, n_n, n_vec, n_count, idx;
    logic [7:0] n_mask;
    bit         n_pass, mis;
    if (!rst_n) begin
      m_phase <= 0; m_n <= 0; m_vec <= 0; m_count <= 0; m_mask <= 8'h00; m_pass <= 1'b0;
    end else begin
      n_phase = m_phase; n_n = m_n; n_vec = m_vec;
      n_count = m_count; n_mask = m_mask; n_pass = m_pass;
      if (m_phase == 2) begin
        n_phase = 0;
      end else if (m_phase == 0) begin
        if (start) begin
          n_phase = 1; n_n = 1; n_vec = 0; n_count = 0; n_mask = 8'h00; n_pass = 1'b0;
        end
      end else begin
        idx = (m_n - 1) / S1;
        if ((m_n % S1) == 0) begin
          mis = (unit(mode, 3'(idx)) != exp_tt[idx]);
          if (mis) begin
            n_mask[idx] = 1'b1;
            n_count     = n_count + 1;
          end
          if (idx == 7 || (EARLY && mis)) begin
            n_phase = 2;
            n_pass  = (n_count == 0);
          end else begin
            n_n = m_n + 1;
          end
        end else begin
          n_n = m_n + 1;
        end
        if (n_phase == 1) n_vec = (n_n - 1) / S1;
      end
      m_phase <= n_phase; m_n <= n_n; m_vec <= n_vec;
      m_count <= n_count; m_mask <= n_mask; m_pass <= n_pass;
    end
  end

  // Per-cycle compare of every output against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_phase == 1});
      chk("done", {31'd0, done}, {31'd0, m_phase == 2});
      chk("vec", {29'd0, vec_a, vec_b, vec_c}, m_vec);
      chk("pass", {31'd0, pass}, {31'd0, m_pass});
      chk("fail_mask", {24'd0, fail_mask}, {24'd0, m_mask});
      chk("fail_count", {28'd0, fail_count}, m_count);
    end
  end

  // Launch a sweep and pin its latency and results with literal values.
  task automatic run_sweep(input int m, input logic [7:0] emask, input int ecnt,
                           input bit epass, input int elat, input bit repulse);
    int cyc;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 100) begin
      start = repulse && (cyc == 5 || cyc == 6);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("latency_m%0d", m), cyc, elat);
    chk($sformatf("mask_m%0d", m), {24'd0, fail_mask}, {24'd0, emask});
    chk($sformatf("count_m%0d", m), {28'd0, fail_count}, ecnt);
    chk($sformatf("pass_m%0d", m), {31'd0, pass}, {31'd0, epass});
    repeat (2) @(negedge clk);
    chk($sformatf("stable_mask_m%0d", m), {24'd0, fail_mask}, {24'd0, emask});
  endtask

  initial begin
    int cyc;
    errors = 0; checks = 0; chk_en = 1'b0;
    exp_tt = 8'h57;
    mode = 0; start = 1'b0; start0 = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vec", {29'd0, vec_a, vec_b, vec_c}, 32'd0);
    chk("rst_mask", {24'd0, fail_mask}, 32'd0);
    chk("rst_count", {28'd0, fail_count}, 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_sweep(0, 8'h00, 0, 1'b1, 25, 1'b0);
    if (EARLY) begin
      run_sweep(1, 8'h08, 1, 1'b0, 13, 1'b0);
      run_sweep(2, 8'h01, 1, 1'b0, 4, 1'b0);
      run_sweep(3, 8'h01, 1, 1'b0, 4, 1'b0);
    end else begin
      run_sweep(1, 8'hA8, 3, 1'b0, 25, 1'b0);
      run_sweep(2, 8'h57, 5, 1'b0, 25, 1'b0);
      run_sweep(3, 8'hFF, 8, 1'b0, 25, 1'b0);
    end
    run_sweep(0, 8'h00, 0, 1'b1, 25, 1'b1);

    // start held high: back-to-back sweeps, checked by the model each cycle.
    mode  = 1;
    start = 1'b1;
    repeat (60) @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (busy !== 1'b0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_start_ends", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a sweep at index 4.
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while ({vec_a, vec_b, vec_c} !== 3'd4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_idx4", {29'd0, vec_a, vec_b, vec_c}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_pass", {31'd0, pass}, 32'd0);
    chk("mid_rst_vec", {29'd0, vec_a, vec_b, vec_c}, 32'd0);
    chk("mid_rst_mask", {24'd0, fail_mask}, 32'd0);
    chk("mid_rst_count", {28'd0, fail_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 8'h00, 0, 1'b1, 25, 1'b0);

    // SETTLE=0 instance: one vector per cycle, done at T0+9.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s0_vec%0d", k), {29'd0, vec_a0, vec_b0, vec_c0}, k);
      chk($sformatf("s0_busy%0d", k), {31'd0, busy0}, 32'd1);
      @(negedge clk);
    end
    chk("s0_done", {31'd0, done0}, 32'd1);
    chk("s0_busy_end", {31'd0, busy0}, 32'd0);
    chk("s0_pass", {31'd0, pass0}, 32'd1);
    chk("s0_mask", {24'd0, fail_mask0}, 32'd0);
    chk("s0_count", {28'd0, fail_count0}, 32'd0);
    @(negedge clk);
    chk("s0_done_pulse", {31'd0, done0}, 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
